// File: rtl/seg_capture_decoder.sv
// ---------------------------------------------------------------------------
// seg_capture_decoder
//
// Watches a seven-segment drive bus and captures each digit that stays
// steady long enough. Accepted glyphs are decoded to a hex value and queued
// in a small FIFO for a valid/ready consumer.
//
// Flow: segments -> seg_q_r -> stability counter -> accept stage ->
//       decode stage -> FIFO -> registered head (out_*).
//
// Parameters
//   STABLE_CYCLES : identical samples needed to accept a pattern (1..255)
//   FIFO_DEPTH    : capture FIFO entries, power of two (2..16)
//
// Ports
//   clk         : clock, rising edge
//   rst         : synchronous active-high reset
//   segments    : segment drive, bit0=a .. bit6=g, active-high
//   out_valid   : FIFO head holds a captured digit
//   out_ready   : consumer takes the head when out_valid=1
//   out_digit   : decoded hex value of the head
//   out_invalid : head pattern matched no glyph (out_digit reads 0)
//   overflow    : sticky, a capture was dropped because the FIFO was full
//   drop_count  : (only with SEGCAP_DROP_COUNT_EN) saturating drop counter
//
// Build option: define SEGCAP_DROP_COUNT_EN to add the drop_count port.
// ---------------------------------------------------------------------------
module seg_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] segments,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_digit,
  output logic       out_invalid,
  output logic       overflow
`ifdef SEGCAP_DROP_COUNT_EN
  ,
  output logic [7:0] drop_count
`endif
);

  localparam int         AW      = $clog2(FIFO_DEPTH);
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK   = 7'h00;

  // Glyph lookup; result is {invalid, digit}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b0, 4'h0};
      7'h06:   res = {1'b0, 4'h1};
      7'h5B:   res = {1'b0, 4'h2};
      7'h4F:   res = {1'b0, 4'h3};
      7'h66:   res = {1'b0, 4'h4};
      7'h6D:   res = {1'b0, 4'h5};
      7'h7D:   res = {1'b0, 4'h6};
      7'h07:   res = {1'b0, 4'h7};
      7'h7F:   res = {1'b0, 4'h8};
      7'h6F:   res = {1'b0, 4'h9};
      7'h77:   res = {1'b0, 4'hA};
      7'h7C:   res = {1'b0, 4'hB};
      7'h39:   res = {1'b0, 4'hC};
      7'h5E:   res = {1'b0, 4'hD};
      7'h79:   res = {1'b0, 4'hE};
      7'h71:   res = {1'b0, 4'hF};
      default: res = {1'b1, 4'h0};
    endcase
    return res;
  endfunction

  // Capture / stability state
  logic [6:0] seg_q_r;
  logic [6:0] cand_r;
  logic [7:0] cnt_r;
  logic [6:0] last_r;
  logic       acc_vld_r;
  logic [6:0] acc_pat_r;
  logic       dec_vld_r;
  logic [4:0] dec_data_r;

  // FIFO state
  logic [4:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        out_valid_r;
  logic [4:0]  head_r;
  logic        overflow_r;

  logic        changed_s;
  logic [7:0]  cnt_nxt_s;
  logic        accept_s;
  logic        full_s;
  logic        pop_s;
  logic        wr_en_s;
  logic        drop_s;
  logic [AW:0] wr_ptr_nxt_s;
  logic [AW:0] rd_ptr_nxt_s;
  logic        valid_nxt_s;
  logic [4:0]  head_nxt_s;

  // Stability counter next value and the single accept strobe per stable run.
  always_comb begin
    changed_s = (seg_q_r != cand_r);
    if (changed_s) begin
      cnt_nxt_s = 8'd0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = cnt_r;
    end else begin
      cnt_nxt_s = cnt_r + 8'd1;
    end
    // A change edge can also be the accept edge when STABLE_CYCLES is 1.
    accept_s = (cnt_nxt_s == CNT_MAX) && (changed_s || (cnt_r != CNT_MAX));
  end

  // FIFO control and next head value for the registered outputs.
  always_comb begin
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s        = out_valid_r && out_ready;
    wr_en_s      = dec_vld_r && (!full_s || pop_s);
    drop_s       = dec_vld_r && full_s && !pop_s;
    wr_ptr_nxt_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
    rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
    valid_nxt_s  = (wr_ptr_nxt_s != rd_ptr_nxt_s);
    // When the new head is the slot being written this edge, forward it.
    if (!valid_nxt_s) begin
      head_nxt_s = 5'd0;
    end else if (rd_ptr_nxt_s == wr_ptr_r) begin
      head_nxt_s = dec_data_r;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
    end
  end

  // Input sample, candidate tracking and stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q_r <= BLANK;
      cand_r  <= BLANK;
      cnt_r   <= 8'd0;
    end else begin
      seg_q_r <= segments;
      cand_r  <= seg_q_r;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Accept stage: blank clears the repeat filter, repeats are suppressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r    <= BLANK;
      acc_vld_r <= 1'b0;
      acc_pat_r <= BLANK;
    end else if (accept_s) begin
      if (seg_q_r == BLANK) begin
        last_r    <= BLANK;
        acc_vld_r <= 1'b0;
      end else if (seg_q_r != last_r) begin
        last_r    <= seg_q_r;
        acc_vld_r <= 1'b1;
        acc_pat_r <= seg_q_r;
      end else begin
        acc_vld_r <= 1'b0;
      end
    end else begin
      acc_vld_r <= 1'b0;
    end
  end

  // Decode stage, registered so the glyph lookup stays off the FIFO path.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_vld_r  <= 1'b0;
      dec_data_r <= 5'd0;
    end else begin
      dec_vld_r  <= acc_vld_r;
      dec_data_r <= decode_glyph(acc_pat_r);
    end
  end

  // FIFO storage; contents need no reset, pointers define occupancy.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= dec_data_r;
    end
  end

  // FIFO pointers, registered head and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      out_valid_r <= 1'b0;
      head_r      <= 5'd0;
      overflow_r  <= 1'b0;
    end else begin
      wr_ptr_r    <= wr_ptr_nxt_s;
      rd_ptr_r    <= rd_ptr_nxt_s;
      out_valid_r <= valid_nxt_s;
      head_r      <= head_nxt_s;
      overflow_r  <= overflow_r | drop_s;
    end
  end

`ifdef SEGCAP_DROP_COUNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of dropped captures.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'hFF)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end else begin
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign drop_count = drop_cnt_r;
`endif

  assign out_valid   = out_valid_r;
  assign out_digit   = head_r[3:0];
  assign out_invalid = head_r[4];
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_seg_capture_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg_capture_decoder
//
// Directed bench for seg_capture_decoder (STABLE_CYCLES=4, FIFO_DEPTH=4).
// Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_seg_capture_decoder;

  logic       clk;
  logic       rst;
  logic [6:0] segments;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_digit;
  logic       out_invalid;
  logic       overflow;
`ifdef SEGCAP_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  int checks;
  int failures;

  seg_capture_decoder #(
    .STABLE_CYCLES(4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .segments   (segments),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digit  (out_digit),
    .out_invalid(out_invalid),
    .overflow   (overflow)
`ifdef SEGCAP_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic hold(input logic [6:0] pat, input int n);
    segments = pat;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_check(input string tag, input logic [3:0] digit, input logic inv);
    check_eq({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check_eq({tag, "_digit"}, {28'd0, out_digit}, {28'd0, digit});
    check_eq({tag, "_inv"}, {31'd0, out_invalid}, {31'd0, inv});
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_empty(input string tag);
    check_eq(tag, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    segments  = 7'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_digit", {28'd0, out_digit}, 32'd0);
    check_eq("rst_inv", {31'd0, out_invalid}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);

    // Latency: 0x06 first sampled at edge 0, out_valid rises at edge 6.
    rst      = 1'b0;
    segments = 7'h06;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("lat_low", {31'd0, out_valid}, 32'd0);
    end
    @(negedge clk);
    check_eq("lat_high", {31'd0, out_valid}, 32'd1);
    check_eq("lat_digit", {28'd0, out_digit}, 32'd1);
    check_eq("lat_inv", {31'd0, out_invalid}, 32'd0);
    hold(7'h06, 10);
    pop_check("hold_one", 4'h1, 1'b0);
    check_empty("hold_single");

    // Short-lived 0x5B must not be captured.
    hold(7'h5B, 2);
    hold(7'h4F, 10);
    pop_check("glitch", 4'h3, 1'b0);
    check_empty("glitch_single");

    // Blank between identical digits allows recapture.
    hold(7'h3F, 8);
    hold(7'h00, 8);
    hold(7'h3F, 8);
    hold(7'h3F, 2);
    pop_check("rep_a", 4'h0, 1'b0);
    pop_check("rep_b", 4'h0, 1'b0);
    check_empty("rep_two");

    // Continuous hold gives one entry.
    hold(7'h00, 8);
    hold(7'h3F, 16);
    pop_check("cont", 4'h0, 1'b0);
    check_empty("cont_single");

    // Unknown glyph.
    hold(7'h00, 8);
    hold(7'h49, 10);
    pop_check("bad_glyph", 4'h0, 1'b1);
    check_empty("bad_single");
    check_eq("ovf_before", {31'd0, overflow}, 32'd0);

    // Overflow: six digits into a four-deep FIFO with no consumer.
    hold(7'h06, 8);
    hold(7'h5B, 8);
    hold(7'h4F, 8);
    hold(7'h66, 8);
    hold(7'h6D, 8);
    hold(7'h7D, 8);
    check_eq("ovf_set", {31'd0, overflow}, 32'd1);
`ifdef SEGCAP_DROP_COUNT_EN
    check_eq("drop_cnt", {24'd0, drop_count}, 32'd2);
`endif
    pop_check("ovf_p1", 4'h1, 1'b0);
    pop_check("ovf_p2", 4'h2, 1'b0);
    pop_check("ovf_p3", 4'h3, 1'b0);
    pop_check("ovf_p4", 4'h4, 1'b0);
    check_empty("ovf_empty");
    check_eq("ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-stream with an entry queued.
    hold(7'h06, 8);
    check_eq("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst      = 1'b1;
    segments = 7'h00;
    @(negedge clk);
    check_eq("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("mid_rst_digit", {28'd0, out_digit}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    hold(7'h00, 4);

    // Full FIFO with a pop on the push edge: no drop.
    hold(7'h06, 8);
    hold(7'h5B, 8);
    hold(7'h4F, 8);
    hold(7'h66, 8);
    segments = 7'h6D;
    repeat (6) @(negedge clk);
    check_eq("full_head", {28'd0, out_digit}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("full_ovf", {31'd0, overflow}, 32'd0);
    hold(7'h6D, 4);
    pop_check("full_p1", 4'h2, 1'b0);
    pop_check("full_p2", 4'h3, 1'b0);
    pop_check("full_p3", 4'h4, 1'b0);
    pop_check("full_p4", 4'h5, 1'b0);
    check_empty("full_empty");
    check_eq("full_ovf_end", {31'd0, overflow}, 32'd0);
`ifdef SEGCAP_DROP_COUNT_EN
    check_eq("full_drop_cnt", {24'd0, drop_count}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
